sync_word_deframer: RTL and testbench

- Sits directly downstream of shift_register_16bit and consumes its 16-bit parallel data_out each time a new serial bit has been shifted in.
- Hunts for a 16-bit sync pattern, then slices the following serial bit stream into WORDS_PER_FRAME 16-bit payload words.
- Delivers payload words through a 2-entry output FIFO with a valid/ready handshake and reports lock, end-of-frame and overflow status.

---
 rtl/sync_word_deframer_if.sv | 27 ++
 rtl/sync_word_deframer.sv | 123 ++++++++++++
 tb/tb_sync_word_deframer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_word_deframer_if.sv
// rtl/sync_word_deframer_if.sv - bit-stream input and payload word output handshake bundle
interface sync_word_deframer_if;
    logic [15:0] shift_word;
    logic        bit_valid;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        first_word;

    modport master (
        input  shift_word,
        input  bit_valid,
        input  word_ready,
        output word_out,
        output word_valid,
        output first_word
    );

    modport slave (
        output shift_word,
        output bit_valid,
        output word_ready,
        input  word_out,
        input  word_valid,
        input  first_word
    );
endinterface

// File: rtl/sync_word_deframer.sv
// rtl/sync_word_deframer.sv - sync hunt, 16-bit payload slicing and 2-entry word FIFO
module sync_word_deframer #(
    parameter logic [15:0] SYNC_WORD       = 16'hA5C3,
    parameter int          WORDS_PER_FRAME = 4
) (
    input  logic                    sh_clk,
    input  logic                    reset,
    sync_word_deframer_if.master    dfr,
    input  logic                    clr_ovf,
    output logic                    locked,
    output logic                    frame_done,
    output logic                    overflow
);
    localparam logic [7:0] LAST_IDX = 8'(WORDS_PER_FRAME - 1);

    typedef enum logic {HUNT, PAYLOAD} state_t;

    state_t      state, state_n;
    logic [3:0]  bit_cnt;
    logic [7:0]  word_cnt;
    logic        capture, last_word;

    logic [15:0] d0, d1, d0_n, d1_n;
    logic        f0, f1, f0_n, f1_n;
    logic [1:0]  cnt, cnt_n;
    logic        pop, drop;

    always_comb begin
        state_n   = state;
        capture   = 1'b0;
        last_word = 1'b0;
        case (state)
            HUNT: begin
                if (dfr.bit_valid && dfr.shift_word == SYNC_WORD)
                    state_n = PAYLOAD;
            end
            PAYLOAD: begin
                if (dfr.bit_valid && bit_cnt == 4'd15) begin
                    capture = 1'b1;
                    if (word_cnt == LAST_IDX) begin
                        last_word = 1'b1;
                        state_n   = HUNT;
                    end
                end
            end
            default: state_n = HUNT;
        endcase
    end

    // Pop first so a capture into a full FIFO that is draining the same cycle is kept.
    always_comb begin
        d0_n  = d0;
        d1_n  = d1;
        f0_n  = f0;
        f1_n  = f1;
        cnt_n = cnt;
        drop  = 1'b0;
        pop   = (cnt != 2'd0) && dfr.word_ready;
        if (pop) begin
            if (cnt == 2'd2) begin
                d0_n = d1;
                f0_n = f1;
            end
            cnt_n = cnt - 2'd1;
        end
        if (capture) begin
            if (cnt_n == 2'd0) begin
                d0_n  = dfr.shift_word;
                f0_n  = (word_cnt == 8'd0);
                cnt_n = 2'd1;
            end else if (cnt_n == 2'd1) begin
                d1_n  = dfr.shift_word;
                f1_n  = (word_cnt == 8'd0);
                cnt_n = 2'd2;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge sh_clk or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            bit_cnt    <= 4'd0;
            word_cnt   <= 8'd0;
            d0         <= 16'h0000;
            d1         <= 16'h0000;
            f0         <= 1'b0;
            f1         <= 1'b0;
            cnt        <= 2'd0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            d0         <= d0_n;
            d1         <= d1_n;
            f0         <= f0_n;
            f1         <= f1_n;
            cnt        <= cnt_n;
            frame_done <= last_word;
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
            // Counters restart on every HUNT bit so a fresh sync always begins at word 0, bit 0.
            if (dfr.bit_valid) begin
                if (state == HUNT) begin
                    bit_cnt  <= 4'd0;
                    word_cnt <= 8'd0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (capture)
                        word_cnt <= word_cnt + 8'd1;
                end
            end
        end
    end

    assign dfr.word_out   = d0;
    assign dfr.word_valid = (cnt != 2'd0);
    assign dfr.first_word = f0 && (cnt != 2'd0);
    assign locked         = (state == PAYLOAD);
endmodule

// File: tb/tb_sync_word_deframer.sv
// tb/tb_sync_word_deframer.sv - randomized and directed bench with queue-based frame model
module tb_sync_word_deframer;
    localparam logic [15:0] SYNC = 16'hA5C3;
    localparam int          WPF  = 4;

    logic sh_clk = 1'b0;
    logic reset;
    logic clr_ovf;
    logic locked, frame_done, overflow;

    always #5 sh_clk = ~sh_clk;

    sync_word_deframer_if bus ();

    sync_word_deframer #(.SYNC_WORD(SYNC), .WORDS_PER_FRAME(WPF)) dut (
        .sh_clk     (sh_clk),
        .reset      (reset),
        .dfr        (bus),
        .clr_ovf    (clr_ovf),
        .locked     (locked),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    typedef struct {
        logic [15:0] d;
        bit          f;
    } ent_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    ent_t        m_q[$];
    logic [15:0] m_hold;
    bit          m_in_frame;
    int          m_nbits;
    bit          m_ovf;
    bit          m_fd;
    logic [15:0] got[$];
    logic [15:0] frame_a[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_hold     = 16'h0000;
        m_in_frame = 1'b0;
        m_nbits    = 0;
        m_ovf      = 1'b0;
        m_fd       = 1'b0;
    endtask

    task automatic cycle(input bit bv, input logic [15:0] sw, input bit rdy, input bit clr);
        bit   drop;
        bit   last;
        int   idx;
        ent_t e;
        @(negedge sh_clk);
        bus.bit_valid  = bv;
        bus.shift_word = sw;
        bus.word_ready = rdy;
        clr_ovf        = clr;
        drop = 1'b0;
        last = 1'b0;
        if (m_q.size() > 0 && rdy) begin
            m_hold = m_q[0].d;
            got.push_back(m_q[0].d);
            void'(m_q.pop_front());
        end
        if (bv) begin
            if (!m_in_frame) begin
                if (sw == SYNC) begin
                    m_in_frame = 1'b1;
                    m_nbits    = 0;
                end
            end else begin
                m_nbits++;
                if (m_nbits % 16 == 0) begin
                    idx = m_nbits / 16 - 1;
                    e.d = sw;
                    e.f = (idx == 0);
                    if (m_q.size() < 2) m_q.push_back(e);
                    else drop = 1'b1;
                    if (idx == WPF - 1) begin
                        last       = 1'b1;
                        m_in_frame = 1'b0;
                    end
                end
            end
        end
        m_fd = last;
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge sh_clk);
        #1;
        chk("word_valid", 32'(bus.word_valid), 32'(m_q.size() > 0));
        chk("word_out", 32'(bus.word_out), 32'(m_q.size() > 0 ? m_q[0].d : m_hold));
        chk("first_word", 32'(bus.first_word), 32'(m_q.size() > 0 && m_q[0].f));
        chk("locked", 32'(locked), 32'(m_in_frame));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic send_frame(input bit rdy, input logic [3:0] cap_rdy, input bit gaps);
        cycle(1'b1, SYNC, rdy, 1'b0);
        for (int w = 0; w < WPF; w++) begin
            for (int b = 0; b < 16; b++) begin
                if (gaps && ($urandom % 2 == 1))
                    cycle(1'b0, 16'($urandom), rdy, 1'b0);
                if (b == 15)
                    cycle(1'b1, frame_a[w], rdy | cap_rdy[w], 1'b0);
                else
                    cycle(1'b1, 16'($urandom), rdy, 1'b0);
            end
        end
    endtask

    task automatic check_got_frame(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(4));
        if (got.size() == 4) begin
            chk({tag, "_w0"}, 32'(got[0]), 32'h0000_BEEF);
            chk({tag, "_w1"}, 32'(got[1]), 32'h0000_0001);
            chk({tag, "_w2"}, 32'(got[2]), 32'h0000_A5C3);
            chk({tag, "_w3"}, 32'(got[3]), 32'h0000_FFFF);
        end
    endtask

    initial begin
        frame_a[0] = 16'hBEEF;
        frame_a[1] = 16'h0001;
        frame_a[2] = 16'hA5C3;
        frame_a[3] = 16'hFFFF;
        reset          = 1'b1;
        bus.bit_valid  = 1'b0;
        bus.shift_word = 16'h0000;
        bus.word_ready = 1'b0;
        clr_ovf        = 1'b0;
        model_reset();
        repeat (2) @(posedge sh_clk);
        #1;
        chk("rst_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_out", 32'(bus.word_out), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge sh_clk);
        reset = 1'b0;

        // non-sync data never locks
        for (int i = 0; i < 20; i++) cycle(1'b1, 16'h1234, 1'b1, 1'b0);
        chk("nosync_locked", 32'(locked), 32'd0);

        // clean frame with consumer always ready
        got.delete();
        send_frame(1'b1, 4'b0000, 1'b0);
        repeat (3) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check_got_frame("frame_rdy");
        chk("frame_rdy_unlocked", 32'(locked), 32'd0);

        // stalled consumer: third and fourth words dropped
        got.delete();
        send_frame(1'b0, 4'b0000, 1'b0);
        chk("stall_ovf", 32'(overflow), 32'd1);
        chk("stall_head", 32'(bus.word_out), 32'h0000_BEEF);
        repeat (3) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("stall_drained", 32'(got.size()), 32'd2);
        if (got.size() == 2) chk("stall_second", 32'(got[1]), 32'h0000_0001);
        chk("stall_empty", 32'(bus.word_valid), 32'd0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // full FIFO drained in the same cycle as a capture
        got.delete();
        send_frame(1'b0, 4'b1100, 1'b0);
        chk("full_pop_ovf", 32'(overflow), 32'd0);
        repeat (3) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check_got_frame("full_pop");

        // reset mid-frame: two words queued, seven bits into the third
        cycle(1'b1, SYNC, 1'b0, 1'b0);
        for (int i = 0; i < 39; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        @(negedge sh_clk);
        bus.bit_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.word_valid), 32'd0);
        chk("midrst_out", 32'(bus.word_out), 32'd0);
        chk("midrst_first", 32'(bus.first_word), 32'd0);
        chk("midrst_locked", 32'(locked), 32'd0);
        model_reset();
        @(negedge sh_clk);
        reset = 1'b0;
        got.delete();
        send_frame(1'b1, 4'b0000, 1'b0);
        repeat (3) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check_got_frame("after_rst");

        // sync pattern without bit_valid is ignored
        for (int i = 0; i < 5; i++) cycle(1'b0, SYNC, 1'b1, 1'b0);
        chk("novalid_locked", 32'(locked), 32'd0);

        // bit_valid gaps inside the payload
        got.delete();
        send_frame(1'b1, 4'b0000, 1'b1);
        repeat (3) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check_got_frame("gaps");

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom % 4) != 0,
                  ($urandom % 6 == 0) ? SYNC : 16'($urandom),
                  ($urandom % 2) == 1,
                  ($urandom % 20) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
